multiply_tree_acc: RTL

//  Pipelined dot-product engine. Each accepted beat multiplies LANES element pairs, reduces them
//  in a registered adder tree, and accumulates the partial sum across beats until a beat tagged

---
 rtl/multiply_tree_acc.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multiply_tree_acc.sv
// rtl/multiply_tree_acc.sv - pipelined multiply / adder-tree / group accumulator with valid-ready output
// Optional feature macro: MAC_TREE_SAT_EN (saturating accumulate and final add).
module multiply_tree_acc #(
    parameter int DATA_WIDTH      = 8,
    parameter int LANES           = 64,
    parameter int ACC_WIDTH       = 32,
    parameter int SIGNED          = 0,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    input  logic [DATA_WIDTH*LANES-1:0]      row,
    input  logic [DATA_WIDTH*LANES-1:0]      col,
    input  logic [ADDRESS_WIDTH_I-1:0]       addr_i_in,
    input  logic [ADDRESS_WIDTH_K-1:0]       addr_k_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_WIDTH-1:0]             out_data,
    output logic [15:0]                      out_beats,
    output logic [ADDRESS_WIDTH_I-1:0]       addr_i_out,
    output logic [ADDRESS_WIDTH_K-1:0]       addr_k_out
);
    localparam int LV = $clog2(LANES);
    localparam int P  = 1 << LV;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int TW = PW + LV;
    // stage 0 = operands, stage 1 = products, stage 1+l = tree level l
    localparam int NS = LV + 2;

    logic                       stall;
    logic [DATA_WIDTH*LANES-1:0] row_q, col_q;
    logic [P*DATA_WIDTH-1:0]    row_pad, col_pad;
    logic [TW-1:0]              prod_d [P];
    logic [TW-1:0]              node_q [LV+1][P];
    logic [NS-1:0]              vld_q, lst_q;
    logic [ADDRESS_WIDTH_I-1:0] ti_q [NS];
    logic [ADDRESS_WIDTH_K-1:0] tk_q [NS];

    logic [TW-1:0]              tree_sum;
    logic [ACC_WIDTH-1:0]       tree_ext, sum_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [15:0]                beats_q, beats_d, beats_inc;
    logic                       out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]       out_data_q, out_data_d;
    logic [15:0]                out_beats_q, out_beats_d;
    logic [ADDRESS_WIDTH_I-1:0] out_i_q, out_i_d;
    logic [ADDRESS_WIDTH_K-1:0] out_k_q, out_k_d;

    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = !stall;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_beats  = out_beats_q;
    assign addr_i_out = out_i_q;
    assign addr_k_out = out_k_q;

    function automatic logic [TW-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                              input logic [DATA_WIDTH-1:0] b);
        logic signed [PW-1:0] ps;
        logic        [PW-1:0] pu;
        ps = $signed(a) * $signed(b);
        pu = a * b;
        return (SIGNED != 0) ? TW'(ps) : TW'(pu);
    endfunction

    // Padded lanes see zero operands, so their products are zero.
    assign row_pad = (P*DATA_WIDTH)'(row_q);
    assign col_pad = (P*DATA_WIDTH)'(col_q);

    always_comb begin
        for (int n = 0; n < P; n++) begin
            prod_d[n] = mul_ext(row_pad[n*DATA_WIDTH +: DATA_WIDTH], col_pad[n*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
            vld_q <= '0;
            lst_q <= '0;
            for (int s = 0; s < NS; s++) begin
                ti_q[s] <= '0;
                tk_q[s] <= '0;
            end
            for (int l = 0; l <= LV; l++) begin
                for (int n = 0; n < P; n++) begin
                    node_q[l][n] <= '0;
                end
            end
        end else if (!stall) begin
            row_q   <= row;
            col_q   <= col;
            vld_q   <= {vld_q[NS-2:0], in_valid && in_ready};
            lst_q   <= {lst_q[NS-2:0], in_last};
            ti_q[0] <= addr_i_in;
            tk_q[0] <= addr_k_in;
            for (int s = 1; s < NS; s++) begin
                ti_q[s] <= ti_q[s-1];
                tk_q[s] <= tk_q[s-1];
            end
            for (int n = 0; n < P; n++) begin
                node_q[0][n] <= prod_d[n];
            end
            // Tree nodes are TW wide, so no level can overflow its sum.
            for (int l = 1; l <= LV; l++) begin
                for (int n = 0; n < (P >> l); n++) begin
                    node_q[l][n] <= node_q[l-1][2*n] + node_q[l-1][2*n+1];
                end
            end
        end
    end

    assign tree_sum = node_q[LV][0];
    assign tree_ext = (SIGNED != 0) ? ACC_WIDTH'($signed(tree_sum)) : ACC_WIDTH'(tree_sum);

`ifdef MAC_TREE_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic [ACC_WIDTH:0] wide;
    logic               ovf, sat_q, sat_d;

    always_comb begin
        if (SIGNED != 0) begin
            wide = {acc_q[ACC_WIDTH-1], acc_q} + {tree_ext[ACC_WIDTH-1], tree_ext};
            ovf  = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
        end else begin
            wide = {1'b0, acc_q} + {1'b0, tree_ext};
            ovf  = wide[ACC_WIDTH];
        end
        // Once clamped, the group stays at the clamp value until its last beat.
        if (sat_q) begin
            sum_d = acc_q;
        end else if (ovf) begin
            sum_d = (SIGNED != 0) ? (wide[ACC_WIDTH] ? SMIN : SMAX) : '1;
        end else begin
            sum_d = wide[ACC_WIDTH-1:0];
        end
        sat_d = sat_q;
        if (!stall && vld_q[NS-1]) begin
            sat_d = lst_q[NS-1] ? 1'b0 : (sat_q || ovf);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    assign sum_d = acc_q + tree_ext;
`endif

    always_comb begin
        acc_d       = acc_q;
        beats_d     = beats_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_i_d     = out_i_q;
        out_k_d     = out_k_q;
        beats_inc   = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
        // Without a stall any held result is being consumed on this edge.
        if (!stall) begin
            out_valid_d = 1'b0;
            if (vld_q[NS-1]) begin
                if (lst_q[NS-1]) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sum_d;
                    out_beats_d = beats_inc;
                    out_i_d     = ti_q[NS-1];
                    out_k_d     = tk_q[NS-1];
                    acc_d       = '0;
                    beats_d     = '0;
                end else begin
                    acc_d   = sum_d;
                    beats_d = beats_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_i_q     <= '0;
            out_k_q     <= '0;
        end else begin
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_i_q     <= out_i_d;
            out_k_q     <= out_k_d;
        end
    end
endmodule
